jtframe_palmix: RTL

Parametrised layer-priority colour mixer with an internal palette RAM. Up to LAYERS tile/sprite layers are merged by fixed priority, the winning pixel is looked up in a CPU-writable 16-bit palette, and blanked 5-5-5 RGB is produced alongside matching delayed blanking signals. It sits between the layer generators and the video output, replacing per-game single-layer mixers.

---
 rtl/jtframe_palmix.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jtframe_palmix.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jtframe_palmix
//  Purpose  : Fixed-priority layer mixer with an internal CPU-writable 16-bit
//             palette. Produces blanked 5-5-5 RGB and blanking delayed to
//             line up with the colour.
//  Ports    : rst, clk            async active-high reset, single clock
//             pxl_cen             pixel clock enable
//             LHBL, LVBL          blanking inputs (active low)
//             pxl, gfx_en         flattened layer pixels, per-layer enables
//             cpu_addr/dout/we    palette byte write port
//             cpu_din             registered palette byte read data
//             red, green, blue    colour output
//             LHBL_dly, LVBL_dly  blanking aligned with the colour output
//  Revision : 1.0 - initial release
// ============================================================================
module jtframe_palmix #(
    parameter int LAYERS = 4,
    parameter int PXLW   = 8,
    parameter int TRANSW = 4
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic                         pxl_cen,
    input  logic                         LHBL,
    input  logic                         LVBL,
    input  logic [LAYERS*PXLW-1:0]       pxl,
    input  logic [LAYERS-1:0]            gfx_en,
    input  logic [$clog2(LAYERS)+PXLW:0] cpu_addr,
    input  logic [7:0]                   cpu_dout,
    input  logic                         cpu_we,
    output logic [7:0]                   cpu_din,
    output logic [4:0]                   red,
    output logic [4:0]                   green,
    output logic [4:0]                   blue,
    output logic                         LHBL_dly,
    output logic                         LVBL_dly
);

    localparam int LW    = $clog2(LAYERS);
    localparam int PALW  = LW + PXLW;
    localparam int DEPTH = 1 << PALW;

    // Palette stored as two byte banks: word = {hi, lo}
    logic [7:0]      r_ram_lo [0:DEPTH-1];
    logic [7:0]      r_ram_hi [0:DEPTH-1];

    logic [PALW-1:0] w_cpu_word;
    logic [PALW-1:0] w_sel_addr;
    logic [14:0]     r_pal_data;   // bit 15 of the palette word carries no colour
    logic            r_lhbl_s1;
    logic            r_lvbl_s1;

    assign w_cpu_word = cpu_addr[PALW:1];

    // Priority select: scanning from the lowest priority upwards lets the
    // lowest-index opaque layer overwrite everything before it.
    always_comb begin
        w_sel_addr = {LW'(LAYERS-1), {PXLW{1'b0}}};
        for (int k = LAYERS-1; k >= 0; k--) begin
            if (gfx_en[k] && (pxl[k*PXLW +: TRANSW] != '0)) begin
                w_sel_addr = {LW'(k), pxl[k*PXLW +: PXLW]};
            end
        end
    end

    // Palette RAM. The video read is taken at the stage-1 pxl_cen edge using
    // the freshly selected address, so the word is ready for stage 2 whether
    // pxl_cen is pulsed or continuous. A CPU write to the same entry on that
    // clk is not seen by this read (old data wins).
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            if (cpu_addr[0]) begin
                r_ram_hi[w_cpu_word] <= cpu_dout;
            end else begin
                r_ram_lo[w_cpu_word] <= cpu_dout;
            end
        end
        if (pxl_cen) begin
            r_pal_data <= {r_ram_hi[w_sel_addr][6:0], r_ram_lo[w_sel_addr]};
        end
    end

    // CPU read-back; a write echoes the new byte on the following clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din <= 8'd0;
        end else if (cpu_we) begin
            cpu_din <= cpu_dout;
        end else begin
            cpu_din <= cpu_addr[0] ? r_ram_hi[w_cpu_word] : r_ram_lo[w_cpu_word];
        end
    end

    // Video pipeline. RGB is gated by the stage-1 blanking, which is the same
    // value that becomes LHBL_dly/LVBL_dly on this edge, keeping them aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lhbl_s1 <= 1'b0;
            r_lvbl_s1 <= 1'b0;
            LHBL_dly  <= 1'b0;
            LVBL_dly  <= 1'b0;
            red       <= 5'd0;
            green     <= 5'd0;
            blue      <= 5'd0;
        end else if (pxl_cen) begin
            r_lhbl_s1 <= LHBL;
            r_lvbl_s1 <= LVBL;
            LHBL_dly  <= r_lhbl_s1;
            LVBL_dly  <= r_lvbl_s1;
            if (r_lhbl_s1 && r_lvbl_s1) begin
                red   <= r_pal_data[14:10];
                green <= r_pal_data[9:5];
                blue  <= r_pal_data[4:0];
            end else begin
                red   <= 5'd0;
                green <= 5'd0;
                blue  <= 5'd0;
            end
        end
    end

endmodule
`default_nettype wire
